// File: rtl/load_store_unit_if.sv
// Core/memory bus bundle for load_store_unit.
// slave  : the load/store unit itself.
// master : the environment, i.e. the core request side plus the data memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed data memory.
// The memory reads combinationally and writes on the clock edge.
// Sub-word stores are done as read-modify-write.
// Optional feature: define LSU_MISALIGN_EN to split misaligned accesses across two
// words. Without it, every misaligned access returns an error.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

  localparam logic [30:0] WORDS = 31'(MEM_WORDS);

  state_t      state_q, state_d;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rd0_q;
  logic [31:0] rd1_q;
  logic        err_q;

  logic        acc_mis;
  logic        acc_err;
  logic        split;
  logic [30:0] acc_idx;
  logic [31:0] idx0;
  logic [31:0] idx1;
  logic [63:0] merged;

  // Legal width codes: stores only 000/001/010; loads additionally allow 100/101.
  function automatic logic code_ok(input logic st, input logic [2:0] f3);
    if (st) return (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
  endfunction

  // Halfword needs an even address; word needs a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    return ((sz == 2'b01) && off[0]) || ((sz == 2'b10) && (off != 2'b00));
  endfunction

  // Select bytes from the two-word window {hi, lo}, then sign- or zero-extend them.
  function automatic logic [31:0] load_extract(input logic [63:0] win, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    sh = 32'(win >> {off, 3'b000});
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  ext = 32'(b);
      3'b001:  ext = 32'(h);
      3'b100:  ext = {24'b0, sh[7:0]};
      3'b101:  ext = {16'b0, sh[15:0]};
      default: ext = sh;
    endcase
    return ext;
  endfunction

  // Overlay the store bytes onto the old two-word window.
  // Bytes that are not addressed keep their old value.
  function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [1:0] off,
                                              input logic [1:0] sz, input logic [31:0] data);
    logic [7:0]  bmask;
    logic [63:0] bits;
    logic [63:0] shifted;
    case (sz)
      2'b00:   bmask = 8'h01;
      2'b01:   bmask = 8'h03;
      default: bmask = 8'h0F;
    endcase
    bmask = bmask << off;
    for (int i = 0; i < 8; i++) bits[i*8 +: 8] = {8{bmask[i]}};
    shifted = {32'b0, data} << {off, 3'b000};
    return (old & ~bits) | (shifted & bits);
  endfunction

  assign acc_idx = {1'b0, bus.req_addr[31:2]};
  assign acc_mis = is_misaligned(bus.req_funct3[1:0], bus.req_addr[1:0]);
  assign idx0    = {2'b00, addr_q[31:2]};
  assign idx1    = idx0 + 32'd1;
  assign merged  = store_merge({rd1_q, rd0_q}, addr_q[1:0], f3_q[1:0], wdata_q);

`ifdef LSU_MISALIGN_EN
  assign acc_err = !code_ok(bus.req_store, bus.req_funct3) || (acc_idx >= WORDS) ||
                   (acc_mis && ((acc_idx + 31'd1) >= WORDS));
  assign split   = is_misaligned(f3_q[1:0], addr_q[1:0]);
`else
  assign acc_err = !code_ok(bus.req_store, bus.req_funct3) || (acc_idx >= WORDS) || acc_mis;
  assign split   = 1'b0;
`endif

  // State register, latched request fields and captured memory words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      rd0_q   <= 32'b0;
      rd1_q   <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid) begin
        store_q <= bus.req_store;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= acc_err;
      end
      if (state_q == RD0) rd0_q <= bus.mem_rdata;
      if (state_q == RD1) rd1_q <= bus.mem_rdata;
    end
  end

  // Next-state selection and bus outputs. Every output is 0 unless a state drives it.
  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'b0;
    bus.resp_err   = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 32'b0;
    bus.mem_wdata  = 32'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = rst;
        if (bus.req_valid && rst) begin
          if (acc_err)
            state_d = RESP;
          else if (bus.req_store && bus.req_funct3 == 3'b010 && !acc_mis)
            state_d = WR0;
          else
            state_d = RD0;
        end
      end
      RD0: begin
        bus.mem_addr = idx0;
        if (split)        state_d = RD1;
        else if (store_q) state_d = WR0;
        else              state_d = RESP;
      end
      RD1: begin
        bus.mem_addr = idx1;
        state_d      = store_q ? WR0 : RESP;
      end
      WR0: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = idx0;
        bus.mem_wdata = merged[31:0];
        state_d       = split ? WR1 : RESP;
      end
      WR1: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = idx1;
        bus.mem_wdata = merged[63:32];
        state_d       = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = (err_q || store_q) ? 32'b0
                                            : load_extract({rd1_q, rd0_q}, addr_q[1:0], f3_q);
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
